// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_SELFCHECK_EN registers a quotient*divisor+remainder consistency flag on check_err.
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          check_err
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [VW:0]   r_r;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;

    logic          w_accept;
    logic          w_last;
    logic [VW:0]   w_t;
    logic          w_ge;
    logic [VW:0]   w_r_nxt;
    logic [DW-1:0] w_q_nxt;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(1));

    // r_r[VW] stays 0 because R < D after every step; folding it in keeps the compare exact regardless.
    assign w_t     = {r_r[VW-1:0], r_q[DW-1]};
    assign w_ge    = r_r[VW] || (w_t >= {1'b0, r_d});
    assign w_r_nxt = w_ge ? (w_t - {1'b0, r_d}) : w_t;
    assign w_q_nxt = {r_q[DW-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= CW'(DW);
            if (divisor == '0) begin
                r_quot <= '1;
                r_rem  <= '0;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_q   <= w_q_nxt;
            r_r   <= w_r_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_quot <= w_q_nxt;
                r_rem  <= w_r_nxt[VW-1:0];
                r_dbz  <= 1'b0;
            end
        end
    end

`ifdef DIV_SELFCHECK_EN
    logic [DW-1:0]    r_dvd;
    logic             r_chk;
    logic [DW+VW-1:0] w_recon;

    assign w_recon = (DW+VW)'(w_q_nxt) * (DW+VW)'(r_d) + (DW+VW)'(w_r_nxt[VW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_chk <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= dividend;
            if (divisor == '0) begin
                r_chk <= 1'b0;
            end
        end else if ((r_state == S_RUN) && w_last) begin
            r_chk <= (w_recon != (DW+VW)'(r_dvd));
        end
    end

    assign check_err = r_chk;
`else
    assign check_err = 1'b0;
`endif

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: driver pushes expected results, negedge monitor pops on done.
module tb_seq_restoring_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          check_err;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .check_err(check_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int            when;
        string         name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_q"},    32'(quotient),    32'(e.q));
                chk({e.name, "_r"},    32'(remainder),   32'(e.r));
                chk({e.name, "_dz"},   32'(div_by_zero), 32'(e.dz));
                chk({e.name, "_cerr"}, 32'(check_err),   32'd0);
                chk({e.name, "_lat"},  32'(cyc),         32'(e.when));
                chk({e.name, "_busy"}, 32'(busy),        32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input string nm);
        exp_t e;
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_idle: got busy=1 expected idle within 100 cycles", nm);
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q    = eq;
        e.r    = er;
        e.dz   = (b == '0);
        e.when = cyc + 1 + ((b == '0) ? 0 : DW);
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_after_accept"}, 32'(busy), (b == '0) ? 32'd0 : 32'd1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", nm, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_busy"}, 32'(busy),        32'd0);
        chk({nm, "_done"}, 32'(done),        32'd0);
        chk({nm, "_q"},    32'(quotient),    32'd0);
        chk({nm, "_r"},    32'(remainder),   32'd0);
        chk({nm, "_dz"},   32'(div_by_zero), 32'd0);
        chk({nm, "_cerr"}, 32'(check_err),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd200, 4'd7,  8'd28,  4'd4, "basic_200_7");
        drain("basic");
        issue(8'd255, 4'd15, 8'd17,  4'd0, "c_255_15");
        issue(8'd5,   4'd9,  8'd0,   4'd5, "c_5_9");
        issue(8'd0,   4'd1,  8'd0,   4'd0, "c_0_1");
        issue(8'd225, 4'd1,  8'd225, 4'd0, "c_225_1");
        drain("corners");
        issue(8'd100, 4'd0,  8'd255, 4'd0, "dbz_100_0");
        drain("dbz");

        // start held through RUN while operands wander; only 200/7 may be used
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        sb.push_back('{q: 8'd28, r: 4'd4, dz: 1'b0, when: cyc + 1 + DW, name: "hold"});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
        end
        start = 1'b0;
        drain("hold");

        // back-to-back: second request lands in the DONE cycle of the first
        issue(8'd77, 4'd6, 8'd12, 4'd5, "b2b_first");
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
        issue(8'd36, 4'd5, 8'd7, 4'd1, "b2b_36_5");
        drain("b2b");

        // reset mid-run at iteration 4
        issue(8'd200, 4'd7, 8'd28, 4'd4, "abort");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'd200, 4'd7, 8'd28, 4'd4, "after_rst");
        drain("after_rst");

`ifdef DIV_SELFCHECK_EN
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(8'(a), 4'(b), 8'(a / b), 4'(a % b), "sweep");
            end
        end
        drain("sweep");
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
